fp32_div: RTL and testbench
===========================

FP32_DIV -- requirements
Module: fp32_div

Interface
REQ-001 SHALL have parameter ITERS, default 25, meaning the number of quotient bits produced, one per cycle (fixed; other values unsupported).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port valid_in  input  1  operand request; sampled only while ready_in=1.
REQ-005 SHALL have port ready_in  output  1  high when idle and able to accept an operand pair.
REQ-006 SHALL have ports a and b  input  32  dividend and divisor, IEEE754 single.
REQ-007 SHALL have port valid_out  output  1  one-cycle pulse marking a new result on y.
REQ-008 SHALL have port y  output  32  quotient a/b, held until the next result.
REQ-009 SHALL have port div_by_zero  output  1  flag for nonzero finite a with zero b, updated with y.

Function
REQ-010 SHALL accept an operation on a rising edge where valid_in=1 and ready_in=1, registering sign, exponents, mantissas and class; valid_in while ready_in=0 SHALL be ignored.
REQ-011 SHALL use FSM states IDLE -> CALC (exactly ITERS cycles) -> PACK (1 cycle) -> IDLE, with ready_in=1 only in IDLE.
REQ-012 SHALL have a fixed latency: valid_out=1 during the cycle beginning 26 clock edges after the accept edge, for every operand class, special cases included.
REQ-013 SHALL flush subnormal inputs (exp=0) to signed zero; normal mantissa = {1,frac} (24 bits).
REQ-014 SHALL use restoring division, initial remainder = ma: per CALC cycle, if rem>=mb then qbit=1 and rem-=mb, else qbit=0; then rem<<=1; q shifts in MSB first; rem width 25 bits.
REQ-015 SHALL compute exponent as signed 10-bit ea-eb+127; if q[24]=1 then frac=q[23:1], else frac=q[22:0] and exponent-=1; truncate with no rounding.
REQ-016 SHALL produce +/-Inf (exp 0xFF, frac 0) when the final exponent is >=255 and signed zero when it is <=0.
REQ-017 SHALL set the result sign to a[31]^b[31] for every result except NaN.
REQ-018 SHALL resolve special cases in priority order: either input NaN, 0/0 or Inf/Inf -> 0x7FC00000; b zero -> signed Inf with div_by_zero=1; a Inf -> signed Inf; a zero or b Inf -> signed zero. These cases SHALL still traverse CALC and PACK (REQ-012).
REQ-019 SHALL hold div_by_zero=0 for all other results.
REQ-020 SHALL update y and div_by_zero only on the PACK->IDLE edge, and SHALL assert valid_out on that edge for exactly one cycle.
REQ-021 SHALL allow back-to-back operation: valid_in=1 in the first IDLE cycle after a result SHALL be accepted on that edge.

Reset
REQ-022 SHALL on rst_n=0, immediately and without a clock, force: state=IDLE, ready_in=1, valid_out=0, y=0x00000000, div_by_zero=0, and clear q, rem and the captured operands.
REQ-023 SHALL abort any in-flight operation when reset is asserted mid-operation; no valid_out SHALL follow the deassertion of reset for the aborted operation.

Structure
REQ-024 SHALL take the following from shared package fp32_pkg: FP32_BIAS (127), FP32_QNAN (0x7FC00000), FP32_EXP_MAX (0xFF), the fp32 class enum (ZERO, NORM, INF, NAN) and the divider state enum (IDLE, CALC, PACK).
REQ-025 SHALL instantiate two copies of one combinational sub-module, fp32_classify (word -> sign, exp, 24-bit mantissa, class), one for a and one for b; the sub-module is reusable by other fp32_* blocks.

Verification
REQ-026 SHALL cover 6.0/2.0: a=0x40C00000, b=0x40000000 -> y=0x40400000, div_by_zero=0, valid_out exactly 26 edges after accept.
REQ-027 SHALL cover 1.0/3.0: a=0x3F800000, b=0x40400000 -> y=0x3EAAAAAA (truncated, not 0x3EAAAAAB).
REQ-028 SHALL cover specials: 0x3F800000/0x00000000 -> 0x7F800000 with div_by_zero=1; 0x00000000/0x00000000 -> 0x7FC00000; 0xBF800000/0x7F800000 -> 0x80000000; each with 26-cycle latency.
REQ-029 SHALL cover range limits: 0x7F000000/0x00800000 -> 0x7F800000 (overflow); 0x00800000/0x40000000 -> 0x00000000 (underflow).
REQ-030 SHALL cover handshake: valid_in held high throughout -> one accept per 27 cycles, ready_in=0 during CALC/PACK, mid-operation operands ignored.
REQ-031 SHALL cover reset: rst_n pulsed low at CALC cycle 10 -> outputs at reset values immediately, no valid_out afterwards, and the next operation returns the correct result.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared definitions for the fp32_* family of arithmetic blocks.
//   FP32_BIAS     exponent bias (127)
//   FP32_QNAN     canonical quiet NaN returned for invalid operations
//   FP32_EXP_MAX  all-ones exponent field (Inf / NaN encodings)
//   fp32_class_e  operand class after subnormal flushing
//   div_state_e   sequencing states of the iterative divider
package fp32_pkg;

    localparam int unsigned FP32_BIAS    = 127;
    localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } fp32_class_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        PACK
    } div_state_e;

    // Assemble a single-precision word from its three fields.
    function automatic logic [31:0] fp32_pack(input logic       i_sign,
                                              input logic [7:0]  i_exp,
                                              input logic [22:0] i_frac);
        return {i_sign, i_exp, i_frac};
    endfunction

endpackage

// File: rtl/fp32_classify.sv
// Combinational field extraction and classification of one IEEE754 single.
//   i_word   operand word
//   o_sign   sign bit
//   o_exp    biased exponent field
//   o_mant   24-bit mantissa with hidden bit; forced to 0 for ZERO class
//   o_class  ZERO (including flushed subnormals), NORM, INF or NAN
module fp32_classify
    import fp32_pkg::*;
(
    input  logic [31:0]  i_word,
    output logic         o_sign,
    output logic [7:0]   o_exp,
    output logic [23:0]  o_mant,
    output fp32_class_e  o_class
);

    always_comb begin
        o_sign  = i_word[31];
        o_exp   = i_word[30:23];
        o_mant  = {1'b1, i_word[22:0]};
        o_class = NORM;
        if (i_word[30:23] == 8'h00) begin
            // Subnormals are flushed: the fraction is discarded, sign kept.
            o_class = ZERO;
            o_mant  = 24'h00_0000;
        end else if (i_word[30:23] == FP32_EXP_MAX) begin
            o_class = (i_word[22:0] == 23'h0) ? INF : NAN;
        end
    end

endmodule

// File: rtl/fp32_div.sv
// Iterative IEEE754 single-precision divider (restoring, one quotient bit
// per clock, truncating, subnormals flushed to zero).
//
// Handshake: an operand pair is taken on a rising edge where valid_in and
// ready_in are both high; ready_in is high only in IDLE, so valid_in is
// ignored while busy. valid_out is a one-cycle pulse, and y/div_by_zero are
// held until the next result. Every operand class takes the same latency.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   valid_in     operand request
//   ready_in     idle and able to accept
//   a, b         dividend, divisor
//   valid_out    result strobe
//   y            quotient a/b
//   div_by_zero  nonzero finite a divided by zero
//   o_dbg_state  current FSM state, for observation only
module fp32_div
    import fp32_pkg::*;
#(
    parameter int ITERS = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    output logic        ready_in,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        valid_out,
    output logic [31:0] y,
    output logic        div_by_zero,
    output div_state_e  o_dbg_state
);

    localparam int CNT_W = $clog2(ITERS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

    // Operand field extraction
    logic        w_sign_a, w_sign_b;
    logic [7:0]  w_exp_a, w_exp_b;
    logic [23:0] w_mant_a, w_mant_b;
    fp32_class_e w_cls_a, w_cls_b;

    fp32_classify u_cls_a (
        .i_word  (a),
        .o_sign  (w_sign_a),
        .o_exp   (w_exp_a),
        .o_mant  (w_mant_a),
        .o_class (w_cls_a)
    );

    fp32_classify u_cls_b (
        .i_word  (b),
        .o_sign  (w_sign_b),
        .o_exp   (w_exp_b),
        .o_mant  (w_mant_b),
        .o_class (w_cls_b)
    );

    // State and datapath registers
    div_state_e      r_state;
    div_state_e      w_state_nxt;
    logic            w_accept;
    logic [CNT_W-1:0] r_cnt;
    logic            r_sign;
    logic [7:0]      r_ea, r_eb;
    logic [24:0]     r_rem;
    logic [23:0]     r_mb;
    logic [24:0]     r_q;
    fp32_class_e     r_cls_a, r_cls_b;
    logic            r_valid_out;
    logic [31:0]     r_y;
    logic            r_dz;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        ready_in    = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                ready_in = 1'b1;
                if (valid_in) begin
                    w_accept    = 1'b1;
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = PACK;
                end
            end
            PACK: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // One restoring step: subtract the divisor if it fits, then shift.
    // The remainder before the shift is always below mb < 2^24, so the
    // shift never loses a significant bit.
    logic        w_ge;
    logic [24:0] w_rem_sub;

    always_comb begin
        w_ge      = (r_rem >= {1'b0, r_mb});
        w_rem_sub = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;
    end

    // Result assembly from the finished quotient and the captured classes.
    logic signed [9:0] w_exp_raw;
    logic signed [9:0] w_exp_fin;
    logic [22:0]       w_frac;
    logic [31:0]       w_inf, w_zero;
    logic [31:0]       w_y_res;
    logic              w_dz_res;

    always_comb begin
        w_exp_raw = $signed({2'b00, r_ea}) - $signed({2'b00, r_eb})
                  + $signed(10'(FP32_BIAS));
        // The quotient lies in (0.5, 2): q[24] tells whether it is >= 1.
        w_exp_fin = r_q[24] ? w_exp_raw : (w_exp_raw - 10'sd1);
        w_frac    = r_q[24] ? r_q[23:1] : r_q[22:0];
        w_inf     = {r_sign, FP32_EXP_MAX, 23'h0};
        w_zero    = {r_sign, 31'h0};
        w_y_res   = w_zero;
        w_dz_res  = 1'b0;
        if ((r_cls_a == NAN) || (r_cls_b == NAN) ||
            ((r_cls_a == ZERO) && (r_cls_b == ZERO)) ||
            ((r_cls_a == INF) && (r_cls_b == INF))) begin
            w_y_res = FP32_QNAN;
        end else if (r_cls_b == ZERO) begin
            w_y_res  = w_inf;
            w_dz_res = (r_cls_a == NORM);
        end else if (r_cls_a == INF) begin
            w_y_res = w_inf;
        end else if ((r_cls_a == ZERO) || (r_cls_b == INF)) begin
            w_y_res = w_zero;
        end else if (w_exp_fin >= 10'sd255) begin
            w_y_res = w_inf;
        end else if (w_exp_fin <= 10'sd0) begin
            w_y_res = w_zero;
        end else begin
            w_y_res = fp32_pack(r_sign, w_exp_fin[7:0], w_frac);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_sign      <= 1'b0;
            r_ea        <= 8'h00;
            r_eb        <= 8'h00;
            r_rem       <= 25'h0;
            r_mb        <= 24'h0;
            r_q         <= 25'h0;
            r_cls_a     <= ZERO;
            r_cls_b     <= ZERO;
            r_valid_out <= 1'b0;
            r_y         <= 32'h0000_0000;
            r_dz        <= 1'b0;
        end else begin
            r_valid_out <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sign  <= w_sign_a ^ w_sign_b;
                        r_ea    <= w_exp_a;
                        r_eb    <= w_exp_b;
                        r_rem   <= {1'b0, w_mant_a};
                        r_mb    <= w_mant_b;
                        r_cls_a <= w_cls_a;
                        r_cls_b <= w_cls_b;
                        r_q     <= 25'h0;
                        r_cnt   <= '0;
                    end
                end
                CALC: begin
                    r_rem <= w_rem_sub << 1;
                    r_q   <= {r_q[23:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                end
                PACK: begin
                    r_y         <= w_y_res;
                    r_dz        <= w_dz_res;
                    r_valid_out <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign valid_out   = r_valid_out;
    assign y           = r_y;
    assign div_by_zero = r_dz;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fp32_div.sv
// Self-checking bench for fp32_div: directed corner cases, randomized
// operands against an arithmetic reference model, a held-valid handshake
// run and a mid-operation reset.
module tb_fp32_div;
    import fp32_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic        ready_in;
    logic [31:0] a;
    logic [31:0] b;
    logic        valid_out;
    logic [31:0] y;
    logic        div_by_zero;
    div_state_e  dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    fp32_div #(.ITERS(25)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .a           (a),
        .b           (b),
        .valid_out   (valid_out),
        .y           (y),
        .div_by_zero (div_by_zero),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [32:0] exp_q[$];   // {div_by_zero, y}
    int          acc_q[$];   // cycle number of the accept edge
    string       tag_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_vo     = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [32:0] ref_div(input logic [31:0] x, input logic [31:0] d);
        logic        s;
        int          ex, ed, e;
        longint      mx, md, q;
        logic [22:0] f;
        bit          zx, zd, ix, id, nx, nd;
        s  = x[31] ^ d[31];
        ex = int'(x[30:23]);
        ed = int'(d[30:23]);
        zx = (ex == 0);
        zd = (ed == 0);
        ix = (ex == 255) && (x[22:0] == 23'h0);
        id = (ed == 255) && (d[22:0] == 23'h0);
        nx = (ex == 255) && (x[22:0] != 23'h0);
        nd = (ed == 255) && (d[22:0] != 23'h0);
        if (nx || nd || (zx && zd) || (ix && id)) return {1'b0, 32'h7FC0_0000};
        if (zd) return {!ix, s, 8'hFF, 23'h0};
        if (ix) return {1'b0, s, 8'hFF, 23'h0};
        if (zx || id) return {1'b0, s, 31'h0};
        mx = longint'({1'b1, x[22:0]});
        md = longint'({1'b1, d[22:0]});
        q  = (mx << 24) / md;          // truncated quotient, 25 significant bits
        e  = ex - ed + 127;
        if (q >= (longint'(1) << 24)) begin
            f = 23'(q >> 1);
        end else begin
            f = 23'(q);
            e = e - 1;
        end
        if (e >= 255) return {1'b0, s, 8'hFF, 23'h0};
        if (e <= 0) return {1'b0, s, 31'h0};
        return {1'b0, s, 8'(e), f};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] w;
        int          sel;
        w   = $urandom;
        sel = $urandom_range(0, 15);
        if (sel == 0) begin
            w[30:23] = 8'h00;                        // zero or subnormal
        end else if (sel == 1) begin
            w[30:23] = 8'hFF;
            w[22:0]  = 23'h0;                        // infinity
        end else if (sel == 2) begin
            w[30:23] = 8'hFF;
            w[22]    = 1'b1;                         // NaN
        end else if (sel <= 4) begin
            w[30:23] = 8'($urandom_range(1, 30));    // near underflow
        end else if (sel <= 6) begin
            w[30:23] = 8'($urandom_range(225, 254)); // near overflow
        end else begin
            w[30:23] = 8'($urandom_range(1, 254));
        end
        return w;
    endfunction

    // ---------------- result monitor ----------------
    always @(posedge clk) begin
        logic [32:0] e;
        string       t;
        #1;
        if (valid_out) begin
            n_vo++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check({t, ".y"}, y, e[31:0]);
                check({t, ".dz"}, div_by_zero, e[32]);
                check({t, ".latency"}, cyc - acc_q.pop_front(), 26);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [32:0] e);
        int t;
        t = 0;
        @(negedge clk);
        while (!ready_in && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!ready_in) check({tag, ".ready_timeout"}, 0, 1);
        a        = ia;
        b        = ib;
        valid_in = 1'b1;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        acc_q.push_back(cyc + 1);
        @(negedge clk);
        valid_in = 1'b0;
        a        = $urandom;
        b        = $urandom;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
            tag_q.delete();
            acc_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ra, rb;
        int          last_acc, k, vo_snap;
        bit          exp_rdy;

        valid_in = 1'b0;
        a        = 32'h0;
        b        = 32'h0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.ready_in", ready_in, 1);
        check("reset.valid_out", valid_out, 0);
        check("reset.y", y, 32'h0);
        check("reset.dz", div_by_zero, 0);
        check("reset.state", dbg_state, IDLE);
        rst_n = 1'b1;

        // Directed corner cases, issued back to back.
        send("6div2",     32'h40C0_0000, 32'h4000_0000, {1'b0, 32'h4040_0000});
        send("1div3",     32'h3F80_0000, 32'h4040_0000, {1'b0, 32'h3EAA_AAAA});
        send("1div0",     32'h3F80_0000, 32'h0000_0000, {1'b1, 32'h7F80_0000});
        send("0div0",     32'h0000_0000, 32'h0000_0000, {1'b0, 32'h7FC0_0000});
        send("m1divinf",  32'hBF80_0000, 32'h7F80_0000, {1'b0, 32'h8000_0000});
        send("overflow",  32'h7F00_0000, 32'h0080_0000, {1'b0, 32'h7F80_0000});
        send("underflow", 32'h0080_0000, 32'h4000_0000, {1'b0, 32'h0000_0000});
        send("nan_in",    32'h7FC0_0001, 32'h3F80_0000, {1'b0, 32'h7FC0_0000});
        send("infdivinf", 32'hFF80_0000, 32'h7F80_0000, {1'b0, 32'h7FC0_0000});
        send("m8divm0",   32'hC100_0000, 32'h8000_0000, {1'b1, 32'h7F80_0000});
        send("subnorm",   32'h0000_0001, 32'h3F80_0000, {1'b0, 32'h0000_0000});
        send("minfdiv2",  32'hFF80_0000, 32'h4000_0000, {1'b0, 32'hFF80_0000});
        wait_drain();

        // Randomized operands against the reference model.
        for (int i = 0; i < 40; i++) begin
            ra = rnd_fp();
            rb = rnd_fp();
            if (ra[30:0] == 31'h7F80_0000 && rb[30:23] == 8'h00) rb[30:23] = 8'd100;
            send("rand", ra, rb, ref_div(ra, rb));
        end
        wait_drain();

        // valid_in held high with operands changing every cycle.
        @(negedge clk);
        last_acc = -1;
        valid_in = 1'b1;
        for (int i = 0; i < 90; i++) begin
            if (i > 0) @(negedge clk);
            ra = rnd_fp();
            rb = rnd_fp();
            if (ra[30:0] == 31'h7F80_0000 && rb[30:23] == 8'h00) rb[30:23] = 8'd7;
            a  = ra;
            b  = rb;
            exp_rdy = (last_acc < 0) || (cyc - last_acc >= 26);
            check("hs.ready_in", ready_in, exp_rdy);
            if (ready_in) begin
                exp_q.push_back(ref_div(ra, rb));
                tag_q.push_back("hs");
                acc_q.push_back(cyc + 1);
                if (last_acc >= 0) check("hs.accept_gap", cyc + 1 - last_acc, 27);
                last_acc = cyc + 1;
            end
        end
        @(negedge clk);
        valid_in = 1'b0;
        wait_drain();

        // Reset pulse in the middle of CALC.
        send("pre_reset", 32'h40C0_0000, 32'h4000_0000, {1'b0, 32'h4040_0000});
        wait_drain();
        send("aborted", 32'h3F80_0000, 32'h4040_0000, {1'b0, 32'h3EAA_AAAA});
        k = acc_q[acc_q.size() - 1];
        while (cyc < k + 9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid.ready_in", ready_in, 1);
        check("rst_mid.valid_out", valid_out, 0);
        check("rst_mid.y", y, 32'h0);
        check("rst_mid.dz", div_by_zero, 0);
        check("rst_mid.state", dbg_state, IDLE);
        exp_q.delete();
        tag_q.delete();
        acc_q.delete();
        vo_snap = n_vo;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("rst_mid.no_valid_out", n_vo - vo_snap, 0);
        send("post_reset", 32'h3F80_0000, 32'h4040_0000, {1'b0, 32'h3EAA_AAAA});
        wait_drain();

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
